// File: rtl/z16_multicycle_ctrl.sv
// Multi-cycle control FSM for the Z16 core: sequences fetch/decode/exec/mem/wb and owns the shared memory port.
// Optional performance counters are built when the macro Z16_CTRL_PERF_EN is defined.
module z16_multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [3:0]  i_opcode,
  input  logic        i_rd_we,
  input  logic        i_mem_we,
  input  logic        i_branch_taken,
  input  logic        i_mem_ack,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_mem_addr_sel,
  output logic        o_ir_we,
  output logic        o_rf_we,
  output logic        o_pc_we,
  output logic        o_pc_sel,
  output logic        o_halted,
  output logic        o_error,
  output logic [2:0]  o_state,
  output logic [31:0] o_retired_cnt,
  output logic [31:0] o_stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'hA;
  localparam logic [3:0] OP_STORE = 4'hB;
  localparam logic [3:0] OP_BRC   = 4'hC;
  localparam logic [3:0] OP_BRD   = 4'hD;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic            req;
  logic            stall;
  logic            timeout_hit;

  // Handshake: a memory transaction is outstanding while req=1 (FETCH or MEM)
  // and completes in any cycle where req=1 and i_mem_ack=1, including the first.
  // Address select and write enable are pure functions of state and the decoder
  // store flag, so they cannot move while a request is outstanding.
  assign req         = (state == S_FETCH) || (state == S_MEM);
  assign stall       = req && !i_mem_ack;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && stall &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      to_cnt <= '0;
    end else begin
      to_cnt <= '0;
      case (state)
        S_IDLE: begin
          if (i_start) state <= S_FETCH;
        end
        S_FETCH: begin
          if (i_mem_ack)        state  <= S_DECODE;
          else if (timeout_hit) state  <= S_ERROR;
          else                  to_cnt <= to_cnt + 1'b1;
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          if ((i_opcode == OP_LOAD) || (i_opcode == OP_STORE)) state <= S_MEM;
          else if (i_opcode == OP_HALT)                         state <= S_HALT;
          else                                                  state <= S_WB;
        end
        S_MEM: begin
          if (i_mem_ack)        state  <= S_WB;
          else if (timeout_hit) state  <= S_ERROR;
          else                  to_cnt <= to_cnt + 1'b1;
        end
        S_WB: state <= S_FETCH;
        S_HALT: begin
          if (i_start) state <= S_FETCH;
        end
        S_ERROR: state <= S_ERROR;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the registered state plus ack so that each fires
  // in exactly one cycle per instruction.
  assign o_mem_req      = req;
  assign o_mem_addr_sel = (state == S_MEM);
  assign o_mem_we       = (state == S_MEM) && i_mem_we;
  assign o_ir_we        = (state == S_FETCH) && i_mem_ack;
  assign o_rf_we        = (state == S_WB) && i_rd_we;
  assign o_pc_we        = (state == S_WB);
  assign o_pc_sel       = (state == S_WB) && i_branch_taken &&
                          ((i_opcode == OP_BRC) || (i_opcode == OP_BRD));
  assign o_halted       = (state == S_HALT);
  assign o_error        = (state == S_ERROR);
  assign o_state        = state;

`ifdef Z16_CTRL_PERF_EN
  logic [31:0] retired_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (state == S_WB) retired_cnt <= retired_cnt + 32'd1;
      if (stall)         stall_cnt   <= stall_cnt + 32'd1;
    end
  end

  assign o_retired_cnt = retired_cnt;
  assign o_stall_cnt   = stall_cnt;
`else
  assign o_retired_cnt = 32'd0;
  assign o_stall_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_z16_multicycle_ctrl.sv
// Directed bench for z16_multicycle_ctrl: instruction flows, wait states, halt, reset and memory timeout.
module tb_z16_multicycle_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [3:0]  i_opcode = 4'h0;
  logic        i_rd_we = 1'b0;
  logic        i_mem_we = 1'b0;
  logic        i_branch_taken = 1'b0;
  logic        i_mem_ack = 1'b0;
  logic        o_mem_req, o_mem_we, o_mem_addr_sel, o_ir_we, o_rf_we;
  logic        o_pc_we, o_pc_sel, o_halted, o_error;
  logic [2:0]  o_state;
  logic [31:0] o_retired_cnt, o_stall_cnt;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int lat_start = 0;

  // Expected output vectors: {req, we, addr_sel, ir_we, rf_we, pc_we, pc_sel, halted, error}
  localparam logic [8:0] O_NONE   = 9'h000;
  localparam logic [8:0] O_FETCH  = 9'h100;
  localparam logic [8:0] O_FETCHA = 9'h120;
  localparam logic [8:0] O_MEM_LD = 9'h140;
  localparam logic [8:0] O_MEM_ST = 9'h1C0;
  localparam logic [8:0] O_WB_RD  = 9'h018;
  localparam logic [8:0] O_WB     = 9'h008;
  localparam logic [8:0] O_WB_BR  = 9'h00C;
  localparam logic [8:0] O_HALT   = 9'h002;
  localparam logic [8:0] O_ERR    = 9'h001;

  z16_multicycle_ctrl #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_opcode(i_opcode),
    .i_rd_we(i_rd_we), .i_mem_we(i_mem_we), .i_branch_taken(i_branch_taken),
    .i_mem_ack(i_mem_ack), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr_sel(o_mem_addr_sel), .o_ir_we(o_ir_we), .o_rf_we(o_rf_we),
    .o_pc_we(o_pc_we), .o_pc_sel(o_pc_sel), .o_halted(o_halted), .o_error(o_error),
    .o_state(o_state), .o_retired_cnt(o_retired_cnt), .o_stall_cnt(o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  // One cycle: drive all inputs just after the falling edge, let outputs settle.
  task automatic cyc(input logic rst, input logic start, input logic ack,
                     input logic [3:0] op, input logic rd_we, input logic mem_we,
                     input logic taken);
    @(negedge i_clk);
    i_rst = rst; i_start = start; i_mem_ack = ack; i_opcode = op;
    i_rd_we = rd_we; i_mem_we = mem_we; i_branch_taken = taken;
    cyc_n++;
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] st, input logic [8:0] ov);
    logic [8:0] act;
    act = {o_mem_req, o_mem_we, o_mem_addr_sel, o_ir_we, o_rf_we,
           o_pc_we, o_pc_sel, o_halted, o_error};
    checks++;
    assert (o_state === st) else begin
      failures++;
      $error("FAIL %s state actual=%0d expected=%0d", tag, o_state, st);
    end
    checks++;
    assert (act === ov) else begin
      failures++;
      $error("FAIL %s outputs actual=%h expected=%h", tag, act, ov);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  initial begin
    // Reset
    cyc(1, 0, 0, 4'h0, 0, 0, 0);
    cyc(1, 0, 0, 4'h0, 0, 0, 0); chk("reset", 3'd0, O_NONE);
    chk32("reset_retired", o_retired_cnt, 32'd0);
    chk32("reset_stall", o_stall_cnt, 32'd0);

    // ALU op 1, zero wait
    cyc(0, 1, 0, 4'h1, 1, 0, 0); chk("idle_start", 3'd0, O_NONE);
    cyc(0, 0, 1, 4'h1, 1, 0, 0); chk("alu_fetch", 3'd1, O_FETCHA);
    cyc(0, 0, 0, 4'h1, 1, 0, 0); chk("alu_decode", 3'd2, O_NONE);
    cyc(0, 0, 0, 4'h1, 1, 0, 0); chk("alu_exec", 3'd3, O_NONE);
    cyc(0, 0, 0, 4'h1, 1, 0, 0); chk("alu_wb", 3'd5, O_WB_RD);

    // Load with 3 wait cycles in MEM
    cyc(0, 0, 1, 4'hA, 1, 0, 0); chk("ld_fetch", 3'd1, O_FETCHA);
    lat_start = cyc_n;
    cyc(0, 0, 0, 4'hA, 1, 0, 0); chk("ld_decode", 3'd2, O_NONE);
    cyc(0, 0, 0, 4'hA, 1, 0, 0); chk("ld_exec", 3'd3, O_NONE);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 4'hA, 1, 0, 0); chk("ld_mem_wait", 3'd4, O_MEM_LD);
    end
    cyc(0, 0, 1, 4'hA, 1, 0, 0); chk("ld_mem_ack", 3'd4, O_MEM_LD);
    cyc(0, 0, 0, 4'hA, 1, 0, 0); chk("ld_wb", 3'd5, O_WB_RD);
    cyc(0, 0, 0, 4'hB, 0, 1, 0); chk("ld_next_fetch", 3'd1, O_FETCH);
    chk32("ld_latency", 32'(cyc_n - lat_start), 32'd8);
`ifdef Z16_CTRL_PERF_EN
    chk32("perf_stall", o_stall_cnt, 32'd3);
    chk32("perf_retired", o_retired_cnt, 32'd2);
`else
    chk32("perf_stall_off", o_stall_cnt, 32'd0);
    chk32("perf_retired_off", o_retired_cnt, 32'd0);
`endif

    // Store: one FETCH wait cycle already taken above, now ack
    cyc(0, 0, 1, 4'hB, 0, 1, 0); chk("st_fetch", 3'd1, O_FETCHA);
    cyc(0, 1, 0, 4'hB, 0, 1, 0); chk("st_decode_start_ign", 3'd2, O_NONE);
    cyc(0, 0, 0, 4'hB, 0, 1, 0); chk("st_exec", 3'd3, O_NONE);
    cyc(0, 0, 1, 4'hB, 0, 1, 0); chk("st_mem", 3'd4, O_MEM_ST);
    cyc(0, 0, 0, 4'hB, 0, 1, 0); chk("st_wb", 3'd5, O_WB);

    // Branch C taken
    cyc(0, 0, 1, 4'hC, 0, 0, 1); chk("brt_fetch", 3'd1, O_FETCHA);
    cyc(0, 0, 0, 4'hC, 0, 0, 1); chk("brt_decode", 3'd2, O_NONE);
    cyc(0, 0, 0, 4'hC, 0, 0, 1); chk("brt_exec", 3'd3, O_NONE);
    cyc(0, 0, 0, 4'hC, 0, 0, 1); chk("brt_wb", 3'd5, O_WB_BR);

    // Branch C not taken
    cyc(0, 0, 1, 4'hC, 0, 0, 0); chk("brn_fetch", 3'd1, O_FETCHA);
    cyc(0, 0, 0, 4'hC, 0, 0, 0); chk("brn_decode", 3'd2, O_NONE);
    cyc(0, 0, 0, 4'hC, 0, 0, 0); chk("brn_exec", 3'd3, O_NONE);
    cyc(0, 0, 0, 4'hC, 0, 0, 0); chk("brn_wb", 3'd5, O_WB);

    // Halt and resume
    cyc(0, 0, 1, 4'hF, 0, 0, 0); chk("halt_fetch", 3'd1, O_FETCHA);
    cyc(0, 0, 0, 4'hF, 0, 0, 0); chk("halt_decode", 3'd2, O_NONE);
    cyc(0, 0, 0, 4'hF, 0, 0, 0); chk("halt_exec", 3'd3, O_NONE);
    cyc(0, 0, 0, 4'hF, 0, 0, 0); chk("halt_1", 3'd6, O_HALT);
    cyc(0, 0, 1, 4'hF, 0, 0, 0); chk("halt_ack_ign", 3'd6, O_HALT);
    cyc(0, 1, 0, 4'hF, 0, 0, 0); chk("halt_start", 3'd6, O_HALT);
    cyc(0, 0, 0, 4'hA, 1, 0, 0); chk("resume_fetch", 3'd1, O_FETCH);

    // Reset during a MEM wait cycle
    cyc(0, 0, 1, 4'hA, 1, 0, 0); chk("rst_fetch", 3'd1, O_FETCHA);
    cyc(0, 0, 0, 4'hA, 1, 0, 0); chk("rst_decode", 3'd2, O_NONE);
    cyc(0, 0, 0, 4'hA, 1, 0, 0); chk("rst_exec", 3'd3, O_NONE);
    cyc(1, 0, 0, 4'hA, 1, 0, 0); chk("rst_in_mem", 3'd4, O_MEM_LD);
    cyc(0, 0, 0, 4'h0, 0, 0, 0); chk("rst_after_mem", 3'd0, O_NONE);
    chk32("rst_retired", o_retired_cnt, 32'd0);
    chk32("rst_stall", o_stall_cnt, 32'd0);

    // Ack on the timeout-limit cycle wins
    cyc(0, 1, 0, 4'h1, 0, 0, 0); chk("tow_idle", 3'd0, O_NONE);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 4'h1, 0, 0, 0); chk("tow_wait", 3'd1, O_FETCH);
    end
    cyc(0, 0, 1, 4'h1, 0, 0, 0); chk("tow_ack_limit", 3'd1, O_FETCHA);
    cyc(0, 0, 0, 4'h1, 0, 0, 0); chk("tow_decode", 3'd2, O_NONE);
    cyc(0, 0, 0, 4'h1, 0, 0, 0); chk("tow_exec", 3'd3, O_NONE);
    cyc(0, 0, 0, 4'h1, 0, 0, 0); chk("tow_wb", 3'd5, O_WB);

    // Timeout in FETCH: ERROR after 5 request cycles
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 4'h1, 0, 0, 0); chk("to_wait", 3'd1, O_FETCH);
    end
    cyc(0, 0, 0, 4'h1, 0, 0, 0); chk("to_error", 3'd7, O_ERR);
    cyc(0, 1, 0, 4'h1, 0, 0, 0); chk("to_start_ign", 3'd7, O_ERR);
    cyc(0, 0, 1, 4'h1, 1, 0, 0); chk("to_ack_ign", 3'd7, O_ERR);
    cyc(1, 0, 0, 4'h1, 1, 0, 0); chk("to_rst_edge", 3'd7, O_ERR);
    cyc(0, 0, 0, 4'h0, 0, 0, 0); chk("to_after_rst", 3'd0, O_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
